// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, latencies and FSM state encodings for the HI/LO multiply/divide unit
package mdu_pkg;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSV   = 3'd7;
    localparam logic [3:0] MUL_LAT  = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MUL    = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational mult/multu and (with MDU_DIV_EN) div/divu producing {hi,lo} plus divide-by-zero flag
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        dz
);
    logic        sgn;
    logic [63:0] ax, bx, prod;
    assign sgn  = (op == OP_MULT) | (op == OP_DIV);
    assign ax   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    assign bx   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    // a 64-bit product of extended operands is exact modulo 2^64 for both signednesses
    assign prod = ax * bx;
`ifdef MDU_DIV_EN
    logic        na, nb, is_div;
    logic [31:0] ua, ub, uq, ur, q, r;
    // divide magnitudes then restore signs, avoiding the INT_MIN/-1 trap of native signed division
    always_comb begin
        na     = sgn & a[31];
        nb     = sgn & b[31];
        ua     = na ? -a : a;
        ub     = nb ? -b : b;
        uq     = (ub == 32'd0) ? 32'd0 : ua / ub;
        ur     = (ub == 32'd0) ? 32'd0 : ua % ub;
        q      = (na ^ nb) ? -uq : uq;
        r      = na ? -ur : ur;
        is_div = (op == OP_DIV) | (op == OP_DIVU);
        res    = is_div ? {r, q} : prod;
        dz     = is_div & (b == 32'd0);
    end
`else
    assign res = prod;
    assign dz  = 1'b0;
`endif
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide controller with fixed-latency commit; MDU_DIV_EN enables div/divu
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    input  logic        md_in_d,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic        dz_q, dz_d;
    logic [63:0] res;
    logic        dz;

    mdu_arith u_arith (.op(op), .a(A), .b(B), .res(res), .dz(dz));

    assign busy  = state_q != S_IDLE;
    assign stall = md_in_d & (busy | (start & (op >= OP_MULT) & (op <= OP_DIVU)));
    assign HI    = hi_q;
    assign LO    = lo_q;

    // launch ops from IDLE into the shadow regs, count down, and commit shadow to HI/LO on the last cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        dz_d    = dz_q;
        if (state_q == S_IDLE) begin
            if (start && (op == OP_MULT || op == OP_MULTU)) begin
                state_d            = S_MUL;
                cnt_d              = MUL_LAT;
                {sh_hi_d, sh_lo_d} = res;
                dz_d               = dz;
            end
`ifdef MDU_DIV_EN
            else if (start && (op == OP_DIV || op == OP_DIVU)) begin
                state_d            = S_DIV;
                cnt_d              = DIV_LAT;
                {sh_hi_d, sh_lo_d} = res;
                dz_d               = dz;
            end
`endif
            else if (start && op == OP_MTHI) hi_d = A;
            else if (start && op == OP_MTLO) lo_d = A;
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = S_IDLE;
                if (!dz_q) begin
                    hi_d = sh_hi_q;
                    lo_d = sh_lo_q;
                end
            end
        end
    end

    // state registers; reset abandons any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sh_hi_q <= 32'd0;
            sh_lo_q <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port start  input  1  E-stage strobe: op/A/B valid this cycle.
REQ-004 SHALL have port op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-005 SHALL have port A  input  32  rs operand.
REQ-006 SHALL have port B  input  32  rt operand.
REQ-007 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-008 SHALL have port stall  output  1  pipeline stall request for any HI/LO instruction in D stage.
REQ-009 SHALL have port md_in_d  input  1  D stage holds mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV with a 4-bit down-counter cnt.
REQ-013 IDLE + start + op in {1,2}: SHALL compute 64-bit product into shadow {sh_hi,sh_lo}, load cnt=5, enter MUL.
REQ-014 IDLE + start + op in {3,4}: SHALL compute quotient into sh_lo, remainder into sh_hi, load cnt=10, enter DIV.
REQ-015 mult/div signed (op 1,3) SHALL use two's-complement; multu/divu unsigned; all results truncated to 32 bits per half.
REQ-016 In MUL/DIV cnt SHALL decrement each cycle; on edge where cnt==1 SHALL write HI<=sh_hi, LO<=sh_lo and return to IDLE.
REQ-017 Latency SHALL be exactly 5 cycles (mult) / 10 cycles (div) from start edge to HI/LO update.
REQ-018 busy SHALL be 1 exactly while state!=IDLE; HI/LO SHALL hold old values until commit.
REQ-019 IDLE + start + op 5/6: SHALL write A to HI/LO on the same edge; busy stays 0.
REQ-020 start while busy SHALL be ignored (no state change); stall prevents this in a correct pipeline.
REQ-021 stall SHALL equal md_in_d & (busy | start-with-op-in-{1..4}); combinational.
REQ-022 Divisor zero SHALL still take 10 cycles and leave HI/LO unchanged at commit.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-024 op 0 or 7 with start SHALL cause no state change.

Reset
REQ-025 reset SHALL asynchronously force state=IDLE, cnt=0, HI=0, LO=0, sh_hi=0, sh_lo=0, busy=0.
REQ-026 reset mid-operation SHALL abandon the operation; no later commit occurs.

Configuration
REQ-027 Macro MDU_DIV_EN defined: div/divu supported per REQ-014.
REQ-028 MDU_DIV_EN undefined: no divider logic; op 3/4 SHALL be treated as no-op (busy stays 0, HI/LO unchanged).

Structure
REQ-029 Op encodings, MUL_LAT=5, DIV_LAT=10 and state encodings SHALL live in shared package mdu_pkg.
REQ-030 Arithmetic SHALL be one sub-module mdu_arith (combinational: op, A, B -> 64-bit result, div-by-zero flag); FSM/counter/HI/LO stay in mdu_ctrl.

Verification
REQ-031 mult A=0xFFFFFFFF B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-032 multu A=0xFFFFFFFF B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-033 div A=-7 B=2 -> 10 cycles busy, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu B=0 -> HI/LO unchanged.
REQ-034 mthi A=0x1234 while IDLE -> HI=0x1234 next edge, busy=0; mtlo during MUL -> ignored, LO=product.
REQ-035 md_in_d=1 during busy -> stall=1 every busy cycle, stall=0 the cycle after commit.
REQ-036 reset asserted at cnt=3 of DIV -> HI=LO=0, busy=0 immediately, no commit after release.
